// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the execute-stage branch controller and the ALU:
// controller states, operation type encodings and branch funct3 codes.
package branch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVAL  = 2'd1,
      ST_REDIR = 2'd2,
      ST_FLUSH = 2'd3
   } state_e;

   localparam logic [1:0] TYPE_BR   = 2'b00;
   localparam logic [1:0] TYPE_JAL  = 2'b01;
   localparam logic [1:0] TYPE_JALR = 2'b10;
   localparam logic [1:0] TYPE_RSV  = 2'b11;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   function automatic logic is_jump(input logic [1:0] op_type);
      return (op_type == TYPE_JAL) || (op_type == TYPE_JALR);
   endfunction

endpackage

// File: rtl/branch_ctrl_branch_unit.sv
// Branch condition comparator. Output is forced low when not enabled or when
// funct3 does not name a branch condition.
module Branch_Unit
   import branch_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int FUNCT3 = 3
) (
   input  logic              en,
   input  logic [FUNCT3-1:0] funct3,
   input  logic [XLEN-1:0]   rs1,
   input  logic [XLEN-1:0]   rs2,
   output logic              taken
);

   // condition decode
   always_comb begin
      taken = 1'b0;
      if (en) begin
         case (funct3)
            BEQ:     taken = (rs1 == rs2);
            BNE:     taken = (rs1 != rs2);
            BLT:     taken = ($signed(rs1) <  $signed(rs2));
            BGE:     taken = ($signed(rs1) >= $signed(rs2));
            BLTU:    taken = (rs1 <  rs2);
            BGEU:    taken = (rs1 >= rs2);
            default: taken = 1'b0;
         endcase
      end else begin
         taken = 1'b0;
      end
   end

endmodule

// File: rtl/branch_ctrl.sv
// Execute-stage branch/jump sequencer: latch op, evaluate for one cycle,
// then redirect fetch and flush the pipeline for taken control transfers.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int FUNCT3    = 3,
   parameter int FLUSH_CYC = 2,
   parameter int CNT_W     = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_type,
   input  logic [FUNCT3-1:0] in_funct3,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_rs1,
   input  logic [XLEN-1:0]   in_rs2,
   output logic              redir_valid,
   input  logic              redir_ready,
   output logic [XLEN-1:0]   redir_pc,
   output logic              flush,
   output logic              link_valid,
   output logic [XLEN-1:0]   link_data,
   output logic              misalign,
   output logic              busy,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  taken_cnt
);

   localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   state_e              state_r;
   logic [1:0]          op_type_r;
   logic [FUNCT3-1:0]   funct3_r;
   logic [XLEN-1:0]     pc_r;
   logic [XLEN-1:0]     imm_r;
   logic [XLEN-1:0]     rs1_r;
   logic [XLEN-1:0]     rs2_r;
   logic [FC_W-1:0]     flush_cnt_r;
   logic                in_ready_r;
   logic                busy_r;
   logic                redir_valid_r;
   logic [XLEN-1:0]     redir_pc_r;
   logic                flush_r;
   logic                link_valid_r;
   logic [XLEN-1:0]     link_data_r;
   logic [CNT_W-1:0]    branch_cnt_r;
   logic [CNT_W-1:0]    taken_cnt_r;

   logic                cmp_en_s;
   logic                cmp_taken_s;
   logic                taken_s;
   logic [XLEN-1:0]     sum_s;
   logic [XLEN-1:0]     target_s;

   assign cmp_en_s = (state_r == ST_EVAL) && (op_type_r == TYPE_BR);

   Branch_Unit #(
      .XLEN   (XLEN),
      .FUNCT3 (FUNCT3)
   ) u_branch_unit (
      .en     (cmp_en_s),
      .funct3 (funct3_r),
      .rs1    (rs1_r),
      .rs2    (rs2_r),
      .taken  (cmp_taken_s)
   );

   // taken decision and target address for the latched operation
   always_comb begin
      sum_s    = pc_r + imm_r;
      target_s = sum_s;
      taken_s  = 1'b0;
      if (op_type_r == TYPE_JALR) begin
         sum_s    = rs1_r + imm_r;
         target_s = {sum_s[XLEN-1:1], 1'b0};
      end else begin
         target_s = sum_s;
      end
      case (op_type_r)
         TYPE_BR:   taken_s = cmp_taken_s;
         TYPE_JAL:  taken_s = 1'b1;
         TYPE_JALR: taken_s = 1'b1;
         default:   taken_s = 1'b0;
      endcase
   end

   // misaligned targets abort the transfer in the evaluation cycle itself
   assign misalign = (state_r == ST_EVAL) && taken_s && target_s[1];

   // sequencer, operand latches, redirect/flush/link outputs and statistics
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r       <= ST_IDLE;
         op_type_r     <= TYPE_BR;
         funct3_r      <= '0;
         pc_r          <= '0;
         imm_r         <= '0;
         rs1_r         <= '0;
         rs2_r         <= '0;
         flush_cnt_r   <= '0;
         in_ready_r    <= 1'b1;
         busy_r        <= 1'b0;
         redir_valid_r <= 1'b0;
         redir_pc_r    <= '0;
         flush_r       <= 1'b0;
         link_valid_r  <= 1'b0;
         link_data_r   <= '0;
         branch_cnt_r  <= '0;
         taken_cnt_r   <= '0;
      end else begin
         link_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  op_type_r    <= in_type;
                  funct3_r     <= in_funct3;
                  pc_r         <= in_pc;
                  imm_r        <= in_imm;
                  rs1_r        <= in_rs1;
                  rs2_r        <= in_rs2;
                  link_valid_r <= is_jump(in_type);
                  link_data_r  <= in_pc + XLEN'(4);
                  in_ready_r   <= 1'b0;
                  busy_r       <= 1'b1;
                  state_r      <= ST_EVAL;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_EVAL: begin
               if (op_type_r == TYPE_BR) begin
                  branch_cnt_r <= (&branch_cnt_r) ? branch_cnt_r : branch_cnt_r + CNT_W'(1);
                  if (taken_s) begin
                     taken_cnt_r <= (&taken_cnt_r) ? taken_cnt_r : taken_cnt_r + CNT_W'(1);
                  end else begin
                     taken_cnt_r <= taken_cnt_r;
                  end
               end else begin
                  branch_cnt_r <= branch_cnt_r;
               end
               if (taken_s && !target_s[1]) begin
                  redir_valid_r <= 1'b1;
                  redir_pc_r    <= target_s;
                  state_r       <= ST_REDIR;
               end else begin
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b0;
                  state_r    <= ST_IDLE;
               end
            end
            ST_REDIR: begin
               if (redir_ready) begin
                  redir_valid_r <= 1'b0;
                  flush_r       <= 1'b1;
                  flush_cnt_r   <= FC_W'(FLUSH_CYC - 1);
                  state_r       <= ST_FLUSH;
               end else begin
                  state_r <= ST_REDIR;
               end
            end
            ST_FLUSH: begin
               if (flush_cnt_r == '0) begin
                  flush_r    <= 1'b0;
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b0;
                  state_r    <= ST_IDLE;
               end else begin
                  flush_cnt_r <= flush_cnt_r - FC_W'(1);
               end
            end
            default: begin
               redir_valid_r <= 1'b0;
               flush_r       <= 1'b0;
               in_ready_r    <= 1'b1;
               busy_r        <= 1'b0;
               state_r       <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_r;
   assign busy        = busy_r;
   assign redir_valid = redir_valid_r;
   assign redir_pc    = redir_pc_r;
   assign flush       = flush_r;
   assign link_valid  = link_valid_r;
   assign link_data   = link_data_r;
   assign branch_cnt  = branch_cnt_r;
   assign taken_cnt   = taken_cnt_r;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: directed ops push expected link/misalign/
// redirect events; a negedge monitor pops and compares them.
module tb_branch_ctrl;
   import branch_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid, in_valid_s;
   logic        in_ready, in_ready_s;
   logic [1:0]  in_type;
   logic [2:0]  in_funct3;
   logic [31:0] in_pc, in_imm, in_rs1, in_rs2;
   logic        redir_valid, redir_valid_s;
   logic        redir_ready, redir_ready_s;
   logic [31:0] redir_pc, redir_pc_s;
   logic        flush, flush_s;
   logic        link_valid, link_valid_s;
   logic [31:0] link_data, link_data_s;
   logic        misalign, misalign_s;
   logic        busy, busy_s;
   logic [15:0] branch_cnt, taken_cnt;
   logic [3:0]  branch_cnt_s, taken_cnt_s;

   int checks = 0;
   int errors = 0;

   localparam int EV_LINK  = 1;
   localparam int EV_MIS   = 2;
   localparam int EV_REDIR = 3;

   typedef struct {
      int          kind;
      logic [31:0] data;
   } ev_t;
   ev_t sb_q[$];

   branch_ctrl dut (
      .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_type(in_type), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .redir_valid(redir_valid),
      .redir_ready(redir_ready), .redir_pc(redir_pc), .flush(flush),
      .link_valid(link_valid), .link_data(link_data), .misalign(misalign),
      .busy(busy), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   branch_ctrl #(.FLUSH_CYC(1), .CNT_W(4)) dut_small (
      .CLK(clk), .RST(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
      .in_type(in_type), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .redir_valid(redir_valid_s),
      .redir_ready(redir_ready_s), .redir_pc(redir_pc_s), .flush(flush_s),
      .link_valid(link_valid_s), .link_data(link_data_s), .misalign(misalign_s),
      .busy(busy_s), .branch_cnt(branch_cnt_s), .taken_cnt(taken_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input logic [31:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input int kind, input logic [31:0] data);
      ev_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_unexpected actual_kind=%0d expected=none", kind);
      end else begin
         e = sb_q.pop_front();
         chk("sb_kind", kind, e.kind);
         if (kind != EV_MIS) chk("sb_data", data, e.data);
      end
   endtask

   // monitor: compares every output event against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (link_valid) sb_pop(EV_LINK, link_data);
         if (misalign) sb_pop(EV_MIS, 32'h0);
         if (redir_valid && redir_ready) sb_pop(EV_REDIR, redir_pc);
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL wait_ready actual=0 expected=1 (timeout)");
      end
   endtask

   // returns in the EVAL cycle (T+1), 1 ns after the edge
   task automatic issue(input logic [1:0] t, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b);
      wait_ready();
      in_type = t; in_funct3 = f3; in_pc = pc; in_imm = imm; in_rs1 = a; in_rs2 = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_valid_s = 1'b0;
      redir_ready = 1'b1; redir_ready_s = 1'b1;
      in_type = 2'b00; in_funct3 = 3'b000;
      in_pc = 32'h0; in_imm = 32'h0; in_rs1 = 32'h0; in_rs2 = 32'h0;
      tick(); tick();
      chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_redir_valid", {31'h0, redir_valid}, 32'h0);
      chk("rst_flush", {31'h0, flush}, 32'h0);
      chk("rst_redir_pc", redir_pc, 32'h0);
      chk("rst_link_data", link_data, 32'h0);
      chk("rst_branch_cnt", {16'h0, branch_cnt}, 32'h0);
      rst = 1'b0;
      tick();

      // BEQ taken, redir_ready high
      push(EV_REDIR, 32'h0000_0120);
      issue(TYPE_BR, BEQ, 32'h100, 32'h20, 32'h5, 32'h5);
      chk("beq_busy", {31'h0, busy}, 32'h1);
      chk("beq_in_ready_eval", {31'h0, in_ready}, 32'h0);
      tick();
      chk("beq_redir_valid", {31'h0, redir_valid}, 32'h1);
      chk("beq_redir_pc", redir_pc, 32'h120);
      chk("beq_branch_cnt", {16'h0, branch_cnt}, 32'h1);
      chk("beq_taken_cnt", {16'h0, taken_cnt}, 32'h1);
      tick();
      chk("beq_flush1", {31'h0, flush}, 32'h1);
      chk("beq_redir_drop", {31'h0, redir_valid}, 32'h0);
      tick();
      chk("beq_flush2", {31'h0, flush}, 32'h1);
      tick();
      chk("beq_flush_end", {31'h0, flush}, 32'h0);
      chk("beq_in_ready", {31'h0, in_ready}, 32'h1);

      // BLT signed taken, BLTU same operands not taken
      push(EV_REDIR, 32'h0000_0210);
      issue(TYPE_BR, BLT, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1);
      tick();
      chk("blt_redir_valid", {31'h0, redir_valid}, 32'h1);
      issue(TYPE_BR, BLTU, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1);
      tick();
      chk("bltu_in_ready", {31'h0, in_ready}, 32'h1);
      chk("bltu_no_redir", {31'h0, redir_valid}, 32'h0);
      chk("bltu_no_flush", {31'h0, flush}, 32'h0);
      chk("bltu_branch_cnt", {16'h0, branch_cnt}, 32'h3);
      chk("bltu_taken_cnt", {16'h0, taken_cnt}, 32'h2);

      // JALR to a misaligned target
      push(EV_LINK, 32'h0000_0044);
      push(EV_MIS, 32'h0);
      issue(TYPE_JALR, 3'b000, 32'h40, 32'h4, 32'h1003, 32'h0);
      chk("jalr_misalign", {31'h0, misalign}, 32'h1);
      chk("jalr_link_valid", {31'h0, link_valid}, 32'h1);
      tick();
      chk("jalr_in_ready", {31'h0, in_ready}, 32'h1);
      chk("jalr_no_redir", {31'h0, redir_valid}, 32'h0);
      chk("jalr_misalign_end", {31'h0, misalign}, 32'h0);

      // JAL wrap-around with fetch stalling the redirect
      redir_ready = 1'b0;
      push(EV_LINK, 32'h0000_0000);
      push(EV_REDIR, 32'h0000_0004);
      issue(TYPE_JAL, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0);
      chk("jal_link_data", link_data, 32'h0);
      tick();
      in_type = TYPE_BR; in_funct3 = BEQ; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("jal_hold_valid", {31'h0, redir_valid}, 32'h1);
         chk("jal_hold_pc", redir_pc, 32'h4);
         chk("jal_hold_ready", {31'h0, in_ready}, 32'h0);
         tick();
      end
      in_valid = 1'b0;
      redir_ready = 1'b1;
      tick();
      chk("jal_flush1", {31'h0, flush}, 32'h1);
      tick();
      chk("jal_flush2", {31'h0, flush}, 32'h1);
      tick();
      chk("jal_in_ready", {31'h0, in_ready}, 32'h1);
      chk("jal_branch_cnt", {16'h0, branch_cnt}, 32'h3);

      // reserved type: nothing happens
      issue(TYPE_RSV, BEQ, 32'h500, 32'h8, 32'h1, 32'h1);
      chk("rsv_no_link", {31'h0, link_valid}, 32'h0);
      tick();
      chk("rsv_in_ready", {31'h0, in_ready}, 32'h1);
      chk("rsv_branch_cnt", {16'h0, branch_cnt}, 32'h3);

      // unknown funct3: counted, not taken
      issue(TYPE_BR, 3'b010, 32'h600, 32'h8, 32'h7, 32'h7);
      tick();
      chk("unk_branch_cnt", {16'h0, branch_cnt}, 32'h4);
      chk("unk_taken_cnt", {16'h0, taken_cnt}, 32'h2);
      chk("unk_no_redir", {31'h0, redir_valid}, 32'h0);

      // reset while a redirect is pending
      redir_ready = 1'b0;
      issue(TYPE_BR, BEQ, 32'h300, 32'h8, 32'h1, 32'h1);
      tick();
      chk("rst_pre_redir", {31'h0, redir_valid}, 32'h1);
      rst = 1'b1;
      #1;
      chk("rstmid_redir_valid", {31'h0, redir_valid}, 32'h0);
      chk("rstmid_busy", {31'h0, busy}, 32'h0);
      chk("rstmid_in_ready", {31'h0, in_ready}, 32'h1);
      chk("rstmid_branch_cnt", {16'h0, branch_cnt}, 32'h0);
      chk("rstmid_taken_cnt", {16'h0, taken_cnt}, 32'h0);
      #2;
      rst = 1'b0;
      redir_ready = 1'b1;
      tick();

      // saturation on the 4-bit counter build
      in_type = TYPE_BR; in_funct3 = BEQ; in_pc = 32'h0; in_imm = 32'h10;
      in_rs1 = 32'h9; in_rs2 = 32'h9;
      for (int i = 0; i < 21; i++) begin
         int n = 0;
         while (!in_ready_s && n < 100) begin
            tick();
            n++;
         end
         chk("sat_wait_ready", {31'h0, in_ready_s}, 32'h1);
         if (i == 15) begin
            chk("sat_branch_15", {28'h0, branch_cnt_s}, 32'hF);
            chk("sat_taken_15", {28'h0, taken_cnt_s}, 32'hF);
         end
         if (i < 20) begin
            in_valid_s = 1'b1;
            tick();
            in_valid_s = 1'b0;
         end
      end
      chk("sat_branch_cnt", {28'h0, branch_cnt_s}, 32'hF);
      chk("sat_taken_cnt", {28'h0, taken_cnt_s}, 32'hF);

      tick(); tick();
      chk("sb_empty", sb_q.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
